// File: rtl/aes_key_expand.sv
// Iterative AES key-expansion engine: one 32-bit schedule word per clock,
// full round-key schedule held in registers until the next start or reset.
`timescale 1ns/1ps
module aes_key_expand #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  output logic [127:0] k_sch [0:Nr],
  output logic         busy,
  output logic         ready
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_key_expand: Nk must be 4, 6 or 8");
  end

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t        state;
  logic [31:0]   w [0:NW-1];
  logic [IW-1:0] i;
  logic [2:0]    i_mod;   // tracks i mod Nk without a divider
  logic [7:0]    rcon;
  logic [31:0]   prev, temp, nxt;

  always_comb begin
    prev = w[i - IW'(1)];
    temp = prev;
    if (i_mod == 3'd0)
      temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    else if (Nk == 8 && i_mod == 3'd4)
      temp = sub_word(prev);
    nxt = w[i - IW'(Nk)] ^ temp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
      i     <= '0;
      i_mod <= '0;
      rcon  <= 8'h01;
      for (int j = 0; j < NW; j++) w[j] <= '0;
    end else if (start) begin
      // Restart is allowed from any state; the key is captured only here.
      for (int j = 0; j < Nk; j++) w[j] <= key[255 - 32*j -: 32];
      i     <= IW'(Nk);
      i_mod <= '0;
      rcon  <= 8'h01;
      ready <= 1'b0;
      busy  <= 1'b1;
      state <= EXPAND;
    end else if (state == EXPAND) begin
      w[i]  <= nxt;
      if (i_mod == 3'd0) rcon <= xtime(rcon);
      i_mod <= (i_mod == 3'(Nk - 1)) ? 3'd0 : i_mod + 3'd1;
      if (i == IW'(NW - 1)) begin
        busy  <= 1'b0;
        ready <= 1'b1;
        state <= IDLE;
      end else begin
        i <= i + IW'(1);
      end
    end
  end

  for (genvar r = 0; r <= Nr; r++) begin : g_ksch
    assign k_sch[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

  // Key bits beyond 32*Nk are intentionally ignored.
  logic unused_key;
  assign unused_key = ^key;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench: three engines (Nk=4/6/8) against an arithmetic
// key-schedule model with an S-box derived from GF(2^8) inversion.
`timescale 1ns/1ps
module tb_aes_key_expand;

  logic         clk, rst;
  logic         start4, start6, start8;
  logic [255:0] key4, key6, key8;
  logic [127:0] ks4 [0:10];
  logic [127:0] ks6 [0:12];
  logic [127:0] ks8 [0:14];
  logic         busy4, busy6, busy8, ready4, ready6, ready8;

  aes_key_expand #(.Nk(4)) u4 (.clk(clk), .rst(rst), .start(start4), .key(key4),
    .k_sch(ks4), .busy(busy4), .ready(ready4));
  aes_key_expand #(.Nk(6)) u6 (.clk(clk), .rst(rst), .start(start6), .key(key6),
    .k_sch(ks6), .busy(busy6), .ready(ready6));
  aes_key_expand #(.Nk(8)) u8 (.clk(clk), .rst(rst), .start(start8), .key(key8),
    .k_sch(ks8), .busy(busy8), .ready(ready8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] FIPS128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] FIPS192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] FIPS256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // ---------------- reference model ----------------
  logic [7:0]   m_sbox_tab [0:255];
  logic [31:0]  mw   [0:59];
  logic [127:0] m_ks [0:14];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] x);
    return {m_sbox_tab[x[31:24]], m_sbox_tab[x[23:16]], m_sbox_tab[x[15:8]], m_sbox_tab[x[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    int nw = 4 * (nk + 7);
    for (int j = 0; j < nk; j++) mw[j] = k[255 - 32*j -: 32];
    for (int j = nk; j < nw; j++) begin
      t = mw[j-1];
      if (j % nk == 0) begin
        t  = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && j % 8 == 4) begin
        t = m_sub(t);
      end
      mw[j] = mw[j-nk] ^ t;
    end
    for (int r = 0; r < nw / 4; r++) m_ks[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endtask

  // ---------------- DUT access ----------------
  function automatic logic get_ready(input int nk);
    return (nk == 4) ? ready4 : (nk == 6) ? ready6 : ready8;
  endfunction

  function automatic logic get_busy(input int nk);
    return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
  endfunction

  function automatic logic [127:0] get_ks(input int nk, input int r);
    return (nk == 4) ? ks4[r] : (nk == 6) ? ks6[r] : ks8[r];
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int ks_mismatches(input int nk);
    int m = 0;
    for (int r = 0; r <= nk + 6; r++) if (get_ks(nk, r) !== m_ks[r]) m++;
    return m;
  endfunction

  function automatic int ks_nonzero();
    int m = 0;
    for (int r = 0; r <= 10; r++) if (ks4[r] !== 128'h0) m++;
    for (int r = 0; r <= 12; r++) if (ks6[r] !== 128'h0) m++;
    for (int r = 0; r <= 14; r++) if (ks8[r] !== 128'h0) m++;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start edge happens inside; the key bus is scrambled right after so the
  // engine must not depend on it past the load edge.
  task automatic drive_start(input int nk, input logic [255:0] k);
    case (nk)
      4: begin start4 = 1'b1; key4 = k; end
      6: begin start6 = 1'b1; key6 = k; end
      default: begin start8 = 1'b1; key8 = k; end
    endcase
    tick();
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = rand_key(); key6 = rand_key(); key8 = rand_key();
  endtask

  task automatic wait_ready(input int nk, output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    while (!get_ready(nk) && n < 200) begin
      if (!get_busy(nk)) busy_low++;
      tick();
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({busy4, busy6, busy8, ready4, ready6, ready8} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000", {busy4, busy6, busy8, ready4, ready6, ready8});
    end
    total++;
    if (ks_nonzero() !== 0) begin
      bad++;
      $display("FAIL reset_ksch nonzero_entries=%0d want=0", ks_nonzero());
    end
    start4 = 1'b1; start6 = 1'b1; start8 = 1'b1;
    key4 = FIPS128; key6 = FIPS192; key8 = FIPS256;
    tick();
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    total++;
    if ({busy4, busy6, busy8, ready4, ready6, ready8} !== 6'b0 || ks_nonzero() !== 0) begin
      bad++;
      $display("FAIL reset_over_start flags=%b nonzero=%0d want=000000/0",
               {busy4, busy6, busy8, ready4, ready6, ready8}, ks_nonzero());
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_aes128();
    int n, bl;
    model_expand(FIPS128, 4);
    drive_start(4, FIPS128);
    wait_ready(4, n, bl);
    total++;
    if (n !== 40 || bl !== 0) begin
      bad++;
      $display("FAIL aes128_latency got=%0d busy_low=%0d want=40/0", n, bl);
    end
    total++;
    if (ks4[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      bad++; $display("FAIL aes128_k0 got=%h", ks4[0]);
    end
    total++;
    if (ks4[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      bad++; $display("FAIL aes128_k1 got=%h want=a0fafe1788542cb123a339392a6c7605", ks4[1]);
    end
    total++;
    if (ks4[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      bad++; $display("FAIL aes128_k10 got=%h want=d014f9a8c9ee2589e13f0cc8b6630ca6", ks4[10]);
    end
    total++;
    if (ks_mismatches(4) !== 0 || busy4 !== 1'b0) begin
      bad++; $display("FAIL aes128_model mismatches=%0d busy=%b want=0/0", ks_mismatches(4), busy4);
    end
  endtask

  task automatic test_aes192();
    int n, bl;
    logic [255:0] k = {FIPS192[255:64], $urandom, $urandom};  // ignored tail bits
    model_expand(k, 6);
    drive_start(6, k);
    wait_ready(6, n, bl);
    total++;
    if (n !== 46 || bl !== 0) begin
      bad++; $display("FAIL aes192_latency got=%0d busy_low=%0d want=46/0", n, bl);
    end
    total++;
    if (ks6[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
      bad++; $display("FAIL aes192_k12 got=%h want=e98ba06f448c773c8ecc720401002202", ks6[12]);
    end
    total++;
    if (ks_mismatches(6) !== 0) begin
      bad++; $display("FAIL aes192_model mismatches=%0d want=0", ks_mismatches(6));
    end
  endtask

  task automatic test_aes256();
    int n, bl;
    model_expand(FIPS256, 8);
    drive_start(8, FIPS256);
    wait_ready(8, n, bl);
    total++;
    if (n !== 52 || bl !== 0) begin
      bad++; $display("FAIL aes256_latency got=%0d busy_low=%0d want=52/0", n, bl);
    end
    total++;
    if (ks8[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      bad++; $display("FAIL aes256_k14 got=%h want=fe4890d1e6188d0b046df344706c631e", ks8[14]);
    end
    total++;
    if (ks_mismatches(8) !== 0) begin
      bad++; $display("FAIL aes256_model mismatches=%0d want=0", ks_mismatches(8));
    end
  endtask

  task automatic test_ready_hold();
    int n, bl;
    logic [255:0] k;
    model_expand(FIPS128, 4);
    for (int c = 0; c < 6; c++) tick();
    total++;
    if (ready4 !== 1'b1 || busy4 !== 1'b0 || ks_mismatches(4) !== 0) begin
      bad++; $display("FAIL ready_hold ready=%b busy=%b mism=%0d want=1/0/0", ready4, busy4, ks_mismatches(4));
    end
    k = rand_key();
    model_expand(k, 4);
    drive_start(4, k);
    total++;
    if (ready4 !== 1'b0 || busy4 !== 1'b1) begin
      bad++; $display("FAIL start_while_ready ready=%b busy=%b want=0/1", ready4, busy4);
    end
    wait_ready(4, n, bl);
    total++;
    if (n !== 40 || ks_mismatches(4) !== 0) begin
      bad++; $display("FAIL start_while_ready_result lat=%0d mism=%0d want=40/0", n, ks_mismatches(4));
    end
  endtask

  task automatic test_restart();
    int n, bl, early = 0;
    drive_start(4, 256'h0);
    for (int c = 0; c < 9; c++) begin
      if (ready4) early++;
      tick();
    end
    drive_start(4, FIPS128);
    wait_ready(4, n, bl);
    total++;
    if (n !== 40 || early !== 0 || bl !== 0) begin
      bad++; $display("FAIL restart_latency got=%0d early=%0d busy_low=%0d want=40/0/0", n, early, bl);
    end
    total++;
    if (ks4[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      bad++; $display("FAIL restart_k10 got=%h want=d014f9a8c9ee2589e13f0cc8b6630ca6", ks4[10]);
    end
  endtask

  task automatic test_rst_mid();
    int n, bl;
    drive_start(4, rand_key());
    for (int c = 0; c < 19; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (busy4 !== 1'b0 || ready4 !== 1'b0 || ks_nonzero() !== 0) begin
      bad++; $display("FAIL rst_mid busy=%b ready=%b nonzero=%0d want=0/0/0", busy4, ready4, ks_nonzero());
    end
    model_expand(FIPS128, 4);
    drive_start(4, FIPS128);
    wait_ready(4, n, bl);
    total++;
    if (n !== 40 || ks_mismatches(4) !== 0) begin
      bad++; $display("FAIL rst_mid_recover lat=%0d mism=%0d want=40/0", n, ks_mismatches(4));
    end
  endtask

  task automatic test_random();
    int n, bl, nk;
    logic [255:0] k;
    for (int it = 0; it < 12; it++) begin
      nk = (it % 3 == 0) ? 4 : (it % 3 == 1) ? 6 : 8;
      k = rand_key();
      model_expand(k, nk);
      drive_start(nk, k);
      wait_ready(nk, n, bl);
      total++;
      if (n !== 4 * (nk + 7) - nk || bl !== 0 || ks_mismatches(nk) !== 0) begin
        bad++;
        $display("FAIL random_nk%0d it=%0d lat=%0d busy_low=%0d mism=%0d want=%0d/0/0",
                 nk, it, n, bl, ks_mismatches(nk), 4 * (nk + 7) - nk);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    for (int x = 0; x < 256; x++) m_sbox_tab[x] = m_sbox(8'(x));
    test_reset();
    test_aes128();
    test_ready_hold();
    test_aes192();
    test_aes256();
    test_restart();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
